ram_16x8_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one 16x8 single-port RAM between requesters A and B. It accepts a read or write command from each requester through a req/gnt handshake. It grants one requester at a time and drives the RAM port for exactly one access cycle. For reads, it returns the RAM output to the winner with a one-cycle rvalid pulse. It sits between the RAM and its two clients.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram_16x8_arbiter_rr_arb2.sv | 23 ++
 rtl/ram_16x8_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_16x8_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester 16x8 RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/ram_16x8_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie, the requester that was not
// granted last wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_e last_grant,
  output logic    valid,
  output req_id_e winner
);

  always_comb begin
    valid  = req_a | req_b;
    winner = REQ_A;
    if (req_a && req_b) begin
      winner = other_id(last_grant);
    end else if (req_b) begin
      winner = REQ_B;
    end
  end

endmodule

// File: rtl/ram_16x8_arbiter.sv
// Shares one single-port 16x8 RAM between requesters A and B: round-robin
// grant, one RAM access cycle per command, read data routed back to its owner.
module ram_16x8_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req/we/addr/wdata until gnt; the command is
  // captured only on the granting edge, so anything driven afterwards is a
  // new command considered at the next IDLE cycle.

  state_e            state_q, state_d;
  req_id_e           last_grant_q, last_grant_d;
  req_id_e           owner_q, owner_d;
  logic              held_we_q, held_we_d;
  logic [ADDR_W-1:0] held_addr_q, held_addr_d;
  logic [DATA_W-1:0] held_wdata_q, held_wdata_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic    arb_valid;
  req_id_e arb_winner;

  rr_arb2 u_rr_arb2 (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    held_we_d    = held_we_q;
    held_addr_d  = held_addr_q;
    held_wdata_d = held_wdata_q;
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    rvalid_a_d   = 1'b0;
    rvalid_b_d   = 1'b0;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          if (arb_winner == REQ_A) begin
            held_we_d    = we_a;
            held_addr_d  = addr_a;
            held_wdata_d = wdata_a;
            gnt_a_d      = 1'b1;
          end else begin
            held_we_d    = we_b;
            held_addr_d  = addr_b;
            held_wdata_d = wdata_b;
            gnt_b_d      = 1'b1;
          end
          owner_d      = arb_winner;
          last_grant_d = arb_winner;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        state_d = held_we_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        // RAM output becomes valid during this cycle; capture it on exit.
        if (owner_q == REQ_A) begin
          rdata_a_d  = ram_dout;
          rvalid_a_d = 1'b1;
        end else begin
          rdata_b_d  = ram_dout;
          rvalid_b_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_B;
      owner_q      <= REQ_A;
      held_we_q    <= 1'b0;
      held_addr_q  <= '0;
      held_wdata_q <= '0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      held_we_q    <= held_we_d;
      held_addr_q  <= held_addr_d;
      held_wdata_q <= held_wdata_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
    end
  end

  // The RAM port is driven straight from the held command, only in ACCESS.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (state_q == ACCESS) begin
      ram_en   = 1'b1;
      ram_we   = held_we_q;
      ram_addr = held_addr_q;
      ram_din  = held_we_q ? held_wdata_q : '0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;

endmodule

// File: tb/tb_ram_16x8_arbiter.sv
// Directed bench for ram_16x8_arbiter with a behavioural 16x8 RAM attached.
module tb_ram_16x8_arbiter;
  import ram_arb_pkg::*;

  logic       clk, reset;
  logic       req_a, we_a, gnt_a, rvalid_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       req_b, we_b, gnt_b, rvalid_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
  logic       ram_en, ram_we, busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [1:0] dbg_state;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       ra;
    logic       wa;
    logic [3:0] aa;
    logic [7:0] da;
    logic       rb;
    logic       wb;
    logic [3:0] ab;
    logic [7:0] db;
    logic [6:0] flags;  // {gnt_a,gnt_b,rvalid_a,rvalid_b,ram_en,ram_we,busy}
    logic [3:0] eaddr;
    logic [7:0] edin;
    logic [7:0] erda;
    logic [7:0] erdb;
  } vec_t;

  vec_t vecs [11];

  ram_16x8_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural RAM: synchronous write, registered read data
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] flags, input logic [3:0] eaddr,
                            input logic [7:0] edin, input logic [7:0] erda, input logic [7:0] erdb);
    check({tag, ".flags"}, {25'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, ram_en, ram_we, busy},
          {25'd0, flags});
    check({tag, ".ram_addr"}, {28'd0, ram_addr}, {28'd0, eaddr});
    check({tag, ".ram_din"}, {24'd0, ram_din}, {24'd0, edin});
    check({tag, ".rdata_a"}, {24'd0, rdata_a}, {24'd0, erda});
    check({tag, ".rdata_b"}, {24'd0, rdata_b}, {24'd0, erdb});
  endtask

  // driver tasks
  task automatic idle_inputs();
    req_a = 1'b0; we_a = 1'b0; addr_a = 4'd0; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; addr_b = 4'd0; wdata_b = 8'h00;
  endtask

  task automatic apply_vec(input vec_t v);
    req_a = v.ra; we_a = v.wa; addr_a = v.aa; wdata_a = v.da;
    req_b = v.rb; we_b = v.wb; addr_b = v.ab; wdata_b = v.db;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       wa;
    int         phase, txn;
    logic [6:0] f;
    logic [3:0] ea;
    logic [7:0] erda;

    // A write AA @5, B read back, then A write 55 @12 contending with B read @12
    vecs[0]  = '{1'b1, 1'b1, 4'd5,  8'hAA, 1'b0, 1'b0, 4'd0,  8'h00, 7'b1000111, 4'd5,  8'hAA, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 7'b0000000, 4'd0,  8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 4'd5,  8'h00, 7'b0100101, 4'd5,  8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 7'b0000001, 4'd0,  8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 7'b0001000, 4'd0,  8'h00, 8'h00, 8'hAA};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 7'b0000000, 4'd0,  8'h00, 8'h00, 8'hAA};
    vecs[6]  = '{1'b1, 1'b1, 4'd12, 8'h55, 1'b1, 1'b0, 4'd12, 8'h00, 7'b1000111, 4'd12, 8'h55, 8'h00, 8'hAA};
    vecs[7]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 4'd12, 8'h00, 7'b0000000, 4'd0,  8'h00, 8'h00, 8'hAA};
    vecs[8]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 4'd12, 8'h00, 7'b0100101, 4'd12, 8'h00, 8'h00, 8'hAA};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 7'b0000001, 4'd0,  8'h00, 8'h00, 8'hAA};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 7'b0001000, 4'd0,  8'h00, 8'h00, 8'h55};

    // reset held with a pending request: nothing moves
    reset = 1'b0;
    idle_inputs();
    req_a = 1'b1;
    repeat (2) begin
      post_edge();
      check_outs("rst", 7'b0000000, 4'd0, 8'h00, 8'h00, 8'h00);
    end
    @(negedge clk) reset = 1'b1;
    post_edge();
    check_outs("rel_gnt", 7'b1000101, 4'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk) req_a = 1'b0;
    post_edge();
    check_outs("rel_wait", 7'b0000001, 4'd0, 8'h00, 8'h00, 8'h00);
    post_edge();
    check_outs("rel_rv", 7'b0010000, 4'd0, 8'h00, 8'h00, 8'h00);

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) apply_vec(vecs[i]);
      post_edge();
      check_outs($sformatf("vec%0d", i), vecs[i].flags, vecs[i].eaddr, vecs[i].edin,
                 vecs[i].erda, vecs[i].erdb);
    end

    // fairness: both requesters read continuously, grants alternate starting with A
    @(negedge clk);
    idle_inputs();
    req_a = 1'b1; addr_a = 4'd5;
    req_b = 1'b1; addr_b = 4'd12;
    for (int c = 0; c < 24; c++) begin
      post_edge();
      phase = c % 3;
      txn   = c / 3;
      wa    = (txn % 2 == 0);
      case (phase)
        0:       begin f = {wa, ~wa, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; ea = wa ? 4'd5 : 4'd12; end
        1:       begin f = 7'b0000001; ea = 4'd0; end
        default: begin f = {1'b0, 1'b0, wa, ~wa, 1'b0, 1'b0, 1'b0}; ea = 4'd0; end
      endcase
      erda = (txn >= 1 || phase == 2) ? 8'hAA : 8'h00;
      check_outs($sformatf("fair%0d", c), f, ea, 8'h00, erda, 8'h55);
    end
    @(negedge clk) idle_inputs();
    post_edge();
    check_outs("fair_end", 7'b0000000, 4'd0, 8'h00, 8'hAA, 8'h55);

    // stability: inputs change after the grant, RAM still sees captured command
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'h33;
    post_edge();
    check_outs("stab_gnt", 7'b1000111, 4'd3, 8'h33, 8'hAA, 8'h55);
    @(negedge clk);
    req_a = 1'b0; addr_a = 4'd9; wdata_a = 8'hFF;
    #1;
    check_outs("stab_hold", 7'b1000111, 4'd3, 8'h33, 8'hAA, 8'h55);
    post_edge();
    check_outs("stab_done", 7'b0000000, 4'd0, 8'h00, 8'hAA, 8'h55);
    check("stab_mem3", {24'd0, mem[3]}, 32'h33);
    check("stab_mem9", {24'd0, mem[9]}, 32'h00);

    // reset during RD_WAIT aborts the read
    @(negedge clk);
    idle_inputs();
    req_a = 1'b1; addr_a = 4'd3;
    post_edge();
    check_outs("mr_gnt", 7'b1000101, 4'd3, 8'h00, 8'hAA, 8'h55);
    @(negedge clk) req_a = 1'b0;
    post_edge();
    check_outs("mr_wait", 7'b0000001, 4'd0, 8'h00, 8'hAA, 8'h55);
    check("mr_state_rdw", {30'd0, dbg_state}, {30'd0, RD_WAIT});
    @(negedge clk) reset = 1'b0;
    #1;
    check_outs("mr_rst", 7'b0000000, 4'd0, 8'h00, 8'h00, 8'h00);
    check("mr_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    post_edge();
    check_outs("mr_hold", 7'b0000000, 4'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk) reset = 1'b1;
    post_edge();
    check_outs("mr_idle", 7'b0000000, 4'd0, 8'h00, 8'h00, 8'h00);

    // the next read after release completes normally
    @(negedge clk);
    req_a = 1'b1; addr_a = 4'd3;
    post_edge();
    check_outs("post_gnt", 7'b1000101, 4'd3, 8'h00, 8'h00, 8'h00);
    @(negedge clk) req_a = 1'b0;
    post_edge();
    check_outs("post_wait", 7'b0000001, 4'd0, 8'h00, 8'h00, 8'h00);
    post_edge();
    check_outs("post_rv", 7'b0010000, 4'd0, 8'h00, 8'h33, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
